// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state, opcode, ALU and write-back codes for the
// cpu_ctrl_fsm control unit.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_LD  = 4'h6;
   localparam logic [3:0] OP_ST  = 4'h7;
   localparam logic [3:0] OP_IN  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_IN  = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/cpu_ctrl_fsm_mem_wait.sv
// cpu_mem_wait: counts consecutive stalled memory cycles and flags
// expiry on the MEM_TO-th one.
module cpu_mem_wait #(
   parameter int MEM_TO = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clear,
   output logic expire
);
   localparam int CW = $clog2(MEM_TO + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (start)
         cnt_d = cnt_q + 1'b1;
      expire = start && (cnt_q == CW'(MEM_TO - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle control FSM for the 8-bit cpu_top datapath.
// Define CPU_SINGLE_STEP_EN to gate every FETCH entry on a step rising edge.
module cpu_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW    = 4,
   parameter int CNTW   = 16,
   parameter int MEM_TO = 15
) (
   input  logic            clk,
   input  logic            ExternalReset,
   input  logic [7:0]      instr,
   input  logic            zero_flag,
   input  logic            mem_ready,
   input  logic            step,
   output logic            ir_load,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            mem_re,
   output logic            mem_we,
   output logic [2:0]      alu_op,
   output logic            reg_we,
   output logic [1:0]      wb_sel,
   output logic            flag_we,
   output logic            out_load,
   output logic            halted,
   output logic            bus_err,
   output logic [CNTW-1:0] instr_count
);
   state_e          state_q, state_d;
   logic [OPW-1:0]  opcode_q, opcode_d, op_in;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            bus_err_q, bus_err_d;
   logic            retire, waiting, expire, go;
   logic            unused_in;

   assign op_in     = instr[7 -: OPW];
   assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
   assign unused_in = ^{instr[7-OPW:0], step};

   cpu_mem_wait #(.MEM_TO(MEM_TO)) u_wait (
      .clk    (clk),
      .rst_n  (ExternalReset),
      .start  (waiting & ~mem_ready),
      .clear  (~waiting | mem_ready),
      .expire (expire)
   );

`ifdef CPU_SINGLE_STEP_EN
   logic step_q, pend_q, pend_d, step_rise;
   assign step_rise = step & ~step_q;
   assign go        = pend_q | step_rise;
   assign pend_d    = (state_d == S_FETCH && state_q != S_FETCH)
                      ? 1'b0 : (pend_q | step_rise);
`else
   assign go = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      bus_err_d = bus_err_q;
      retire    = 1'b0;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            opcode_d = op_in;
            unique case (op_in)
               OP_HLT: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
               OP_NOP, 4'hC, 4'hD, 4'hE: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            unique case (opcode_q)
               OP_LD, OP_ST: state_d = S_MEM;
               OP_OUT, OP_JMP, OP_JZ: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (opcode_q == OP_LD) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (expire) begin
         state_d   = S_HALT;
         bus_err_d = 1'b1;
      end
      // With stepping enabled IDLE doubles as the wait-for-step state
      if (state_d == S_FETCH && state_q != S_FETCH && !go)
         state_d = S_IDLE;
      cnt_d = cnt_q + CNTW'(retire);
   end

   always_comb begin
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      alu_op   = ALU_PASS;
      reg_we   = 1'b0;
      wb_sel   = WB_ALU;
      flag_we  = 1'b0;
      out_load = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_re  = 1'b1;
            ir_load = mem_ready;
            pc_inc  = mem_ready;
         end
         S_EXEC: begin
            unique case (opcode_q)
               OP_ADD: begin alu_op = ALU_ADD; flag_we = 1'b1; end
               OP_SUB: begin alu_op = ALU_SUB; flag_we = 1'b1; end
               OP_AND: begin alu_op = ALU_AND; flag_we = 1'b1; end
               OP_OR:  begin alu_op = ALU_OR;  flag_we = 1'b1; end
               OP_OUT: out_load = 1'b1;
               OP_JMP: pc_load  = 1'b1;
               OP_JZ:  pc_load  = zero_flag;
               default: ;
            endcase
         end
         S_MEM: begin
            mem_re = (opcode_q == OP_LD);
            mem_we = (opcode_q == OP_ST);
         end
         S_WB: begin
            reg_we = 1'b1;
            unique case (opcode_q)
               OP_LD:   wb_sel = WB_MEM;
               OP_IN:   wb_sel = WB_IN;
               OP_LDI:  wb_sel = WB_IMM;
               default: wb_sel = WB_ALU;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign bus_err     = bus_err_q;
   assign instr_count = cnt_q;

   always_ff @(posedge clk) begin
      if (!ExternalReset) begin
         state_q   <= S_IDLE;
         opcode_q  <= '0;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
`ifdef CPU_SINGLE_STEP_EN
         step_q    <= 1'b0;
         pend_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
`ifdef CPU_SINGLE_STEP_EN
         step_q    <= step;
         pend_q    <= pend_d;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed and random checks of cpu_ctrl_fsm against an
// instruction-sequence reference model.
module tb_cpu_ctrl_fsm;
   localparam int MEM_TO = 15;
   localparam int PH_F = 0, PH_D = 1, PH_X = 2, PH_M = 3, PH_W = 4;
   localparam int MD_IDLE = 0, MD_RUN = 1, MD_HALT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, mem_ready = 1'b0, zero_flag = 1'b0, step = 1'b0;
   logic [7:0]  instr = 8'h00;
   logic        ir_load, pc_inc, pc_load, mem_re, mem_we, reg_we;
   logic        flag_we, out_load, halted, bus_err;
   logic [2:0]  alu_op;
   logic [1:0]  wb_sel;
   logic [15:0] instr_count;
   logic [13:0] dut_s;

   assign dut_s = {ir_load, pc_inc, pc_load, mem_re, mem_we, alu_op,
                   reg_we, wb_sel, flag_we, out_load, halted};

   cpu_ctrl_fsm dut (
      .clk(clk), .ExternalReset(rst_n), .instr(instr),
      .zero_flag(zero_flag), .mem_ready(mem_ready), .step(step),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
      .mem_re(mem_re), .mem_we(mem_we), .alu_op(alu_op),
      .reg_we(reg_we), .wb_sel(wb_sel), .flag_we(flag_we),
      .out_load(out_load), .halted(halted), .bus_err(bus_err),
      .instr_count(instr_count)
   );

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;

   int          m_mode = MD_IDLE, m_pos = 0, m_wait = 0;
   logic [3:0]  m_op = 4'h0;
   logic [15:0] m_cnt = 16'h0;
   logic        m_berr = 1'b0, m_pend = 1'b0, m_stq = 1'b0;
   logic [7:0]  ir = 8'h00, mem_word = 8'h00;

   // Phase list per opcode: F D [X] [M] [W]
   function automatic int seq_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8: return 4;
         4'h6:             return 5;
         4'h9, 4'hA, 4'hB: return 3;
         default:          return 2;
      endcase
   endfunction

   function automatic int phase_of(input logic [3:0] op, input int pos);
      if (pos == 3) return (op == 4'h6 || op == 4'h7) ? PH_M : PH_W;
      return pos;
   endfunction

   function automatic logic [13:0] model_out(input logic mr, input logic zf);
      logic il = 0, pi = 0, pl = 0, re = 0, we = 0;
      logic rw = 0, fw = 0, ol = 0, h = 0;
      logic [2:0] ao = 0;
      logic [1:0] ws = 0;
      if (m_mode == MD_HALT) begin
         h = 1;
      end else if (m_mode == MD_RUN) begin
         case (phase_of(m_op, m_pos))
            PH_F: begin re = 1; il = mr; pi = mr; end
            PH_X: begin
               case (m_op)
                  4'h2: begin ao = 3'd1; fw = 1; end
                  4'h3: begin ao = 3'd2; fw = 1; end
                  4'h4: begin ao = 3'd3; fw = 1; end
                  4'h5: begin ao = 3'd4; fw = 1; end
                  4'h9: ol = 1;
                  4'hA: pl = 1;
                  4'hB: pl = zf;
                  default: ;
               endcase
            end
            PH_M: begin
               if (m_op == 4'h6) re = 1;
               else we = 1;
            end
            PH_W: begin
               rw = 1;
               ws = (m_op == 4'h6) ? 2'd1 : (m_op == 4'h8) ? 2'd2 :
                    (m_op == 4'h1) ? 2'd3 : 2'd0;
            end
            default: ;
         endcase
      end
      return {il, pi, pl, re, we, ao, rw, ws, fw, ol, h};
   endfunction

   always @(posedge clk) begin
      logic edge_s, gate, entered;
      int ph;
      if (!rst_n) begin
         m_mode = MD_IDLE; m_pos = 0; m_wait = 0;
         m_cnt = 0; m_berr = 0; m_pend = 0; m_stq = 0;
      end else begin
`ifdef CPU_SINGLE_STEP_EN
         edge_s = step && !m_stq;
         gate   = m_pend || edge_s;
         m_stq  = step;
`else
         edge_s = 1'b0;
         gate   = 1'b1;
`endif
         entered = 1'b0;
         if (m_mode == MD_IDLE) begin
            if (gate) begin m_mode = MD_RUN; m_pos = 0; entered = 1'b1; end
         end else if (m_mode == MD_RUN) begin
            ph = phase_of(m_op, m_pos);
            if ((ph == PH_F || ph == PH_M) && !mem_ready) begin
               m_wait++;
               if (m_wait == MEM_TO) begin m_mode = MD_HALT; m_berr = 1'b1; end
            end else begin
               m_wait = 0;
               if (ph == PH_F) ir = mem_word;
               if (ph == PH_D) m_op = instr[7:4];
               if (m_pos + 1 == seq_len(m_op)) begin
                  m_cnt++;
                  if (m_op == 4'hF) m_mode = MD_HALT;
                  else if (gate) begin m_pos = 0; entered = 1'b1; end
                  else m_mode = MD_IDLE;
               end else begin
                  m_pos++;
               end
            end
         end
         m_pend = entered ? 1'b0 : (m_pend || edge_s);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (dut_s !== model_out(mem_ready, zero_flag)) begin
            n_bad++;
            $display("FAIL strobes t=%0t act=%h req=%h", $time, dut_s,
                     model_out(mem_ready, zero_flag));
         end
         n_cmp++;
         if ({bus_err, instr_count} !== {m_berr, m_cnt}) begin
            n_bad++;
            $display("FAIL berr_count t=%0t act=%b/%0d req=%b/%0d", $time,
                     bus_err, instr_count, m_berr, m_cnt);
         end
      end
   end

   task automatic lit(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s act=%0h req=%0h", nm, act, req);
      end
   endtask

   task automatic tick(input logic rn, input logic mr, input logic zf,
                       input logic [7:0] w);
      @(posedge clk);
      #1;
      rst_n = rn; mem_ready = mr; zero_flag = zf; mem_word = w; instr = ir;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int hold;
      int stall;
      hold = 0;
      stall = 0;
      tick(0, 0, 0, 8'h00);
      tick(0, 0, 0, 8'h00);
      chk_en = 1'b1;
`ifndef CPU_SINGLE_STEP_EN
      tick(1, 1, 0, 8'h25);
      lit("rst_idle_strobes", dut_s, 0);
      lit("rst_count", instr_count, 0);
      lit("rst_berr", bus_err, 0);
      tick(1, 1, 0, 8'h25);
      lit("fetch_mem_re", mem_re, 1);
      lit("fetch_ir_load", ir_load, 1);
      tick(1, 1, 0, 8'h25);
      lit("decode_quiet", dut_s, 0);
      tick(0, 1, 0, 8'h25);
      lit("exec_add_alu", alu_op, 1);
      lit("exec_add_flag", flag_we, 1);
      tick(0, 1, 0, 8'h25);
      lit("midrst_idle", dut_s, 0);
      lit("midrst_count", instr_count, 0);
      tick(0, 1, 0, 8'h25);
      tick(1, 1, 0, 8'h25);
      lit("rst_hold_idle", dut_s, 0);
      tick(1, 1, 0, 8'h25);
      lit("release_fetch", mem_re, 1);
      tick(1, 1, 0, 8'h25);
      tick(1, 1, 0, 8'h25);
      lit("add_alu_op", alu_op, 1);
      lit("add_flag_we", flag_we, 1);
      tick(1, 1, 0, 8'h25);
      lit("add_wb_reg_we", reg_we, 1);
      lit("add_wb_sel", wb_sel, 0);
      tick(1, 1, 0, 8'h60);
      lit("add_count", instr_count, 1);
      tick(1, 1, 0, 8'h60);
      tick(1, 0, 0, 8'h60);
      lit("ld_exec_quiet", dut_s, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0, 8'h60);
         lit("ld_mem_re_stall", mem_re, 1);
      end
      tick(1, 1, 0, 8'h60);
      lit("ld_mem_re_ready", mem_re, 1);
      tick(1, 1, 0, 8'hB4);
      lit("ld_wb_sel", wb_sel, 1);
      lit("ld_wb_reg_we", reg_we, 1);
      tick(1, 1, 0, 8'hB4);
      lit("ld_count", instr_count, 2);
      tick(1, 1, 1, 8'hB4);
      tick(1, 1, 1, 8'hB4);
      lit("jz_taken", pc_load, 1);
      tick(1, 1, 0, 8'hB4);
      lit("jz_back_fetch", mem_re, 1);
      lit("jz_count", instr_count, 3);
      tick(1, 1, 0, 8'hB4);
      tick(1, 1, 0, 8'hB4);
      lit("jz_not_taken", pc_load, 0);
      tick(1, 0, 0, 8'hF0);
      lit("jz2_count", instr_count, 4);
      for (int i = 0; i < 14; i++) tick(1, 0, 0, 8'hF0);
      lit("to_not_yet", halted, 0);
      lit("to_still_fetch", mem_re, 1);
      tick(1, 1, 0, 8'hF0);
      lit("to_halted", halted, 1);
      lit("to_bus_err", bus_err, 1);
      lit("to_halt_only", dut_s, 14'h1);
      tick(0, 1, 0, 8'hF0);
      lit("halt_ignores_ready", halted, 1);
      tick(1, 1, 0, 8'hF0);
      lit("berr_cleared", bus_err, 0);
      tick(1, 1, 0, 8'hF0);
      tick(1, 1, 0, 8'hF0);
      tick(1, 1, 0, 8'hF0);
      lit("hlt_halted", halted, 1);
      lit("hlt_count", instr_count, 1);
`else
      step = 1'b1;
      for (int i = 0; i < 20; i++) tick(1, 1, 0, 8'h25);
      lit("step_held_count", instr_count, 1);
      lit("step_held_idle", dut_s, 0);
      step = 1'b0;
      tick(1, 1, 0, 8'h25);
      tick(1, 1, 0, 8'h25);
      step = 1'b1;
      tick(1, 1, 0, 8'h25);
      step = 1'b0;
      for (int i = 0; i < 10; i++) tick(1, 1, 0, 8'h25);
      lit("step_pulse_count", instr_count, 2);
`endif
      tick(0, 1, 0, 8'h00);
      for (int i = 0; i < 4000; i++) begin
         logic rn, mr;
         logic [7:0] w;
         w = 8'($urandom);
         if (w[7:4] == 4'hF && $urandom_range(0, 7) != 0) w[7:4] = 4'h2;
         rn = ($urandom_range(0, 199) != 0);
         if (m_mode == MD_HALT) hold++;
         if (hold > 3) begin rn = 1'b0; hold = 0; end
         if (stall > 0) begin
            mr = 1'b0;
            stall--;
         end else if ($urandom_range(0, 299) == 0) begin
            mr = 1'b0;
            stall = 17;
         end else begin
            mr = ($urandom_range(0, 3) != 0);
         end
         step = ($urandom_range(0, 3) == 0);
         tick(rn, mr, 1'($urandom), w);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
